// File: rtl/cipher_mode_engine.sv
// Streaming XOR-keystream cipher engine supporting ECB, CBC and CTR chaining
// with a one-word output holding register and ready/valid handshakes.
module cipher_mode_engine #(
  parameter int unsigned BLOCK_SIZE = 8,
  parameter int unsigned SYNC_SIZE  = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BLOCK_SIZE-1:0] key,
  input  logic [SYNC_SIZE-1:0]  iv,
  input  logic [1:0]            mode,
  input  logic                  decrypt,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SYNC_SIZE-1:0]  data_plain,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SYNC_SIZE-1:0]  data_encrypted,
  output logic                  out_last,
  output logic                  busy,
  output logic [CNT_W-1:0]      word_count
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    ModeEcb = 2'b00,
    ModeCbc = 2'b01,
    ModeCtr = 2'b10,
    ModeRsv = 2'b11
  } mode_e;

  state_e                r_state;
  state_e                w_state_next;

  logic [BLOCK_SIZE-1:0] r_key;
  logic [SYNC_SIZE-1:0]  r_cv;
  mode_e                 r_mode;
  logic                  r_decrypt;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [SYNC_SIZE-1:0]  r_data;
  logic [CNT_W-1:0]      r_count;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_out_fire;
  logic                  w_start_ok;
  logic [SYNC_SIZE-1:0]  w_keystream;
  logic [SYNC_SIZE-1:0]  w_result;
  logic [SYNC_SIZE-1:0]  w_cv_next;

  // A new word may enter whenever the holding register is empty or draining now.
  assign w_in_ready = (r_state == StRun) & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_start_ok = start & (r_state == StIdle);

  // Key bits repeat cyclically across the data word.
  always_comb begin
    w_keystream = '0;
    for (int i = 0; i < int'(SYNC_SIZE); i++) begin
      w_keystream[i] = r_key[i % BLOCK_SIZE];
    end
  end

  always_comb begin
    w_result  = data_plain ^ w_keystream;
    w_cv_next = r_cv;
    unique case (r_mode)
      ModeCbc: begin
        w_result  = data_plain ^ w_keystream ^ r_cv;
        w_cv_next = r_decrypt ? data_plain : w_result;
      end
      ModeCtr: begin
        w_result  = data_plain ^ w_keystream ^ r_cv;
        w_cv_next = r_cv + SYNC_SIZE'(1);
      end
      ModeEcb, ModeRsv: begin
        w_result  = data_plain ^ w_keystream;
        w_cv_next = r_cv;
      end
      default: begin
        w_result  = data_plain ^ w_keystream;
        w_cv_next = r_cv;
      end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StRun;
      StRun:   if (w_accept && in_last) w_state_next = StDrain;
      StDrain: if (w_out_fire) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key       <= '0;
      r_cv        <= '0;
      r_mode      <= ModeEcb;
      r_decrypt   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_data      <= '0;
      r_count     <= '0;
    end else begin
      if (w_start_ok) begin
        r_key     <= key;
        r_cv      <= iv;
        r_mode    <= mode_e'(mode);
        r_decrypt <= decrypt;
        r_count   <= '0;
      end
      // Accept takes priority so a simultaneous drain+fill keeps out_valid high.
      if (w_accept) begin
        r_data      <= w_result;
        r_out_last  <= in_last;
        r_out_valid <= 1'b1;
        r_cv        <= w_cv_next;
        r_count     <= r_count + CNT_W'(1);
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready       = w_in_ready;
  assign out_valid      = r_out_valid;
  assign data_encrypted = r_data;
  assign out_last       = r_out_last;
  assign busy           = (r_state != StIdle);
  assign word_count     = r_count;

endmodule

// File: tb/tb_cipher_mode_engine.sv
// Directed bench for cipher_mode_engine: ECB/CBC/CTR vectors, backpressure, reset.
module tb_cipher_mode_engine;

  logic        clk;
  logic        rst;
  logic [7:0]  key;
  logic [15:0] iv;
  logic [1:0]  mode;
  logic        decrypt;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_plain;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_encrypted;
  logic        out_last;
  logic        busy;
  logic [15:0] word_count;

  int n_checks = 0;
  int n_fail   = 0;

  cipher_mode_engine #(
    .BLOCK_SIZE(8),
    .SYNC_SIZE (16),
    .CNT_W     (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key           (key),
    .iv            (iv),
    .mode          (mode),
    .decrypt       (decrypt),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_plain    (data_plain),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data_encrypted(data_encrypted),
    .out_last      (out_last),
    .busy          (busy),
    .word_count    (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session(input logic [7:0] k, input logic [15:0] v, input logic [1:0] m,
                               input logic d);
    key = k; iv = v; mode = m; decrypt = d; start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble session inputs; the latched copies must be used.
    key = 8'h3c; iv = 16'h1111; mode = 2'b11; decrypt = ~d;
  endtask

  initial begin
    rst = 1'b1; key = '0; iv = '0; mode = '0; decrypt = 1'b0; start = 1'b0;
    in_valid = 1'b0; data_plain = '0; in_last = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {16'd0, word_count}, 32'd0);
    chk("rst_data", {16'd0, data_encrypted}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;

    // ECB
    begin_session(8'ha5, 16'h0000, 2'b00, 1'b0);
    chk("ecb_busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b1; data_plain = 16'h1234; in_last = 1'b1; out_ready = 1'b0;
    #1;
    chk("ecb_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("ecb_data", {16'd0, data_encrypted}, 32'h0000b791);
    chk("ecb_valid", {31'd0, out_valid}, 32'd1);
    chk("ecb_count", {16'd0, word_count}, 32'd1);
    chk("ecb_last", {31'd0, out_last}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("ecb_valid_clr", {31'd0, out_valid}, 32'd0);
    chk("ecb_idle", {31'd0, busy}, 32'd0);

    // CBC encrypt
    begin_session(8'ha5, 16'h00ff, 2'b01, 1'b0);
    in_valid = 1'b1; data_plain = 16'h1234; in_last = 1'b0;
    tick();
    chk("cbce_w0", {16'd0, data_encrypted}, 32'h0000b76e);
    chk("cbce_w0_last", {31'd0, out_last}, 32'd0);
    data_plain = 16'h0000; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("cbce_w1", {16'd0, data_encrypted}, 32'h000012cb);
    chk("cbce_w1_last", {31'd0, out_last}, 32'd1);
    chk("cbce_count", {16'd0, word_count}, 32'd2);
    tick();
    chk("cbce_idle", {31'd0, busy}, 32'd0);

    // CBC decrypt
    begin_session(8'ha5, 16'h00ff, 2'b01, 1'b1);
    in_valid = 1'b1; data_plain = 16'hb76e; in_last = 1'b0;
    tick();
    chk("cbcd_w0", {16'd0, data_encrypted}, 32'h00001234);
    data_plain = 16'h12cb; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("cbcd_w1", {16'd0, data_encrypted}, 32'h00000000);
    tick();

    // CTR with counter wrap
    begin_session(8'ha5, 16'hffff, 2'b10, 1'b0);
    in_valid = 1'b1; data_plain = 16'h0000; in_last = 1'b0;
    tick();
    chk("ctr_w0", {16'd0, data_encrypted}, 32'h00005a5a);
    in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("ctr_w1", {16'd0, data_encrypted}, 32'h0000a5a5);
    tick();
    chk("ctr_idle", {31'd0, busy}, 32'd0);

    // Backpressure
    begin_session(8'ha5, 16'h0000, 2'b00, 1'b0);
    in_valid = 1'b1; data_plain = 16'h0001; in_last = 1'b0; out_ready = 1'b0;
    tick();
    chk("bp_w0", {16'd0, data_encrypted}, 32'h0000a5a4);
    data_plain = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_data_hold", {16'd0, data_encrypted}, 32'h0000a5a4);
      chk("bp_count_hold", {16'd0, word_count}, 32'd1);
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_w1", {16'd0, data_encrypted}, 32'h0000a5a7);
    chk("bp_w1_valid", {31'd0, out_valid}, 32'd1);
    data_plain = 16'h0003;
    tick();
    chk("bp_w2", {16'd0, data_encrypted}, 32'h0000a5a6);
    chk("bp_w2_count", {16'd0, word_count}, 32'd3);
    data_plain = 16'h0004; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    chk("bp_w3", {16'd0, data_encrypted}, 32'h0000a5a1);
    chk("bp_w3_count", {16'd0, word_count}, 32'd4);

    // start while draining must be ignored
    key = 8'hff; mode = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    chk("drain_start_busy", {31'd0, busy}, 32'd1);
    chk("drain_start_count", {16'd0, word_count}, 32'd4);
    chk("drain_start_data", {16'd0, data_encrypted}, 32'h0000a5a1);
    out_ready = 1'b1;
    tick();
    chk("drain_idle", {31'd0, busy}, 32'd0);

    // Reset mid-session with held output
    begin_session(8'ha5, 16'h0000, 2'b00, 1'b0);
    in_valid = 1'b1; data_plain = 16'h1234; in_last = 1'b0; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("mid_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_count", {16'd0, word_count}, 32'd0);
    chk("mid_rst_data", {16'd0, data_encrypted}, 32'd0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1; data_plain = 16'h5555;
    tick();
    in_valid = 1'b0;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_count", {16'd0, word_count}, 32'd0);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
